// File: rtl/ledpanel_write_arbiter.sv
// Round-robin arbiter for the ledpanel video-memory write port, with an optional frame-clear engine.
// The frame-clear engine is built only when LEDPANEL_ARB_CLEAR_EN is defined.
module ledpanel_write_arbiter #(
   parameter int CHAINED    = 1,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  ctrl_clk,
   input  logic                  ctrl_rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [3:0]            req0_wr,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [23:0]           req0_wdat,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [3:0]            req1_wr,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [23:0]           req1_wdat,
   input  logic                  clear_start,
   input  logic [23:0]           clear_color,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic                  addr_err,
   output logic                  ctrl_en,
   output logic [3:0]            ctrl_wr,
   output logic [ADDR_WIDTH-1:0] ctrl_addr,
   output logic [23:0]           ctrl_wdat
);

   localparam int DEPTH = CHAINED * 4096;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

   logic                  en_q, en_d;
   logic [3:0]            wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [23:0]           wdat_q, wdat_d;
   logic                  err_q, err_d;
   logic                  rr_q, rr_d;
   logic                  arbOpen;
   logic                  grant0, grant1;
   logic [3:0]            selWr;
   logic [ADDR_WIDTH-1:0] selAddr;
   logic [23:0]           selWdat;

`ifdef LEDPANEL_ARB_CLEAR_EN
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {ARB, CLEAR} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0]   color_q, color_d;
   logic          done_q, done_d;
   logic          unusedBits;

   assign unusedBits = ^{req0_wr[3], req1_wr[3]};
   assign arbOpen    = (state_q == ARB) && !clear_start;
   assign clear_busy = (state_q == CLEAR);
   assign clear_done = done_q;
`else
   logic unusedBits;

   assign unusedBits = ^{req0_wr[3], req1_wr[3], clear_start, clear_color};
   assign arbOpen    = 1'b1;
   assign clear_busy = 1'b0;
   assign clear_done = 1'b0;
`endif

   // rr_q names the side that wins when both requesters are valid
   assign grant0  = arbOpen && req0_valid && (!req1_valid || !rr_q);
   assign grant1  = arbOpen && req1_valid && (!req0_valid || rr_q);
   assign selWr   = grant1 ? req1_wr   : req0_wr;
   assign selAddr = grant1 ? req1_addr : req0_addr;
   assign selWdat = grant1 ? req1_wdat : req0_wdat;

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      en_d   = 1'b0;
      wr_d   = 4'b0000;
      addr_d = addr_q;
      wdat_d = wdat_q;
      err_d  = 1'b0;
      rr_d   = rr_q;
`ifdef LEDPANEL_ARB_CLEAR_EN
      state_d = state_q;
      cnt_d   = cnt_q;
      color_d = color_q;
      done_d  = 1'b0;
`endif
      if (grant0 || grant1) begin
         rr_d = grant0;
         if ({1'b0, selAddr} >= DEPTH_L) begin
            err_d = 1'b1;
         end else begin
            en_d   = 1'b1;
            wr_d   = {1'b0, selWr[2:0]};
            addr_d = selAddr;
            wdat_d = selWdat;
         end
      end
`ifdef LEDPANEL_ARB_CLEAR_EN
      // The start cycle already issues address 0, so cnt_q always holds the next address to fill
      unique case (state_q)
         ARB: begin
            if (clear_start) begin
               state_d = CLEAR;
               color_d = clear_color;
               en_d    = 1'b1;
               wr_d    = 4'b0111;
               addr_d  = '0;
               wdat_d  = clear_color;
               cnt_d   = CW'(1);
            end
         end
         CLEAR: begin
            if (cnt_q == DEPTH_C) begin
               state_d = ARB;
               cnt_d   = '0;
            end else begin
               en_d   = 1'b1;
               wr_d   = 4'b0111;
               addr_d = ADDR_WIDTH'(cnt_q);
               wdat_d = color_q;
               cnt_d  = cnt_q + CW'(1);
               done_d = (cnt_q == DEPTH_C - CW'(1));
            end
         end
         default: state_d = ARB;
      endcase
`endif
   end

   always_ff @(posedge ctrl_clk) begin
      if (ctrl_rst) begin
         en_q   <= 1'b0;
         wr_q   <= 4'b0000;
         addr_q <= '0;
         wdat_q <= '0;
         err_q  <= 1'b0;
         rr_q   <= 1'b0;
`ifdef LEDPANEL_ARB_CLEAR_EN
         state_q <= ARB;
         cnt_q   <= '0;
         color_q <= '0;
         done_q  <= 1'b0;
`endif
      end else begin
         en_q   <= en_d;
         wr_q   <= wr_d;
         addr_q <= addr_d;
         wdat_q <= wdat_d;
         err_q  <= err_d;
         rr_q   <= rr_d;
`ifdef LEDPANEL_ARB_CLEAR_EN
         state_q <= state_d;
         cnt_q   <= cnt_d;
         color_q <= color_d;
         done_q  <= done_d;
`endif
      end
   end

   assign ctrl_en   = en_q;
   assign ctrl_wr   = wr_q;
   assign ctrl_addr = addr_q;
   assign ctrl_wdat = wdat_q;
   assign addr_err  = err_q;

endmodule

// File: tb/tb_ledpanel_write_arbiter.sv
// Directed bench for ledpanel_write_arbiter; clear-engine steps run only when LEDPANEL_ARB_CLEAR_EN is defined.
module tb_ledpanel_write_arbiter;

   logic        ctrl_clk = 1'b0;
   logic        ctrl_rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_wr, req1_wr;
   logic [15:0] req0_addr, req1_addr;
   logic [23:0] req0_wdat, req1_wdat;
   logic        clear_start;
   logic [23:0] clear_color;
   logic        clear_busy, clear_done, addr_err;
   logic        ctrl_en;
   logic [3:0]  ctrl_wr;
   logic [15:0] ctrl_addr;
   logic [23:0] ctrl_wdat;

   int tests  = 0;
   int failed = 0;

   ledpanel_write_arbiter #(.CHAINED(1), .ADDR_WIDTH(16)) dut (
      .ctrl_clk   (ctrl_clk),
      .ctrl_rst   (ctrl_rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_wr    (req0_wr),
      .req0_addr  (req0_addr),
      .req0_wdat  (req0_wdat),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_wr    (req1_wr),
      .req1_addr  (req1_addr),
      .req1_wdat  (req1_wdat),
      .clear_start(clear_start),
      .clear_color(clear_color),
      .clear_busy (clear_busy),
      .clear_done (clear_done),
      .addr_err   (addr_err),
      .ctrl_en    (ctrl_en),
      .ctrl_wr    (ctrl_wr),
      .ctrl_addr  (ctrl_addr),
      .ctrl_wdat  (ctrl_wdat)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge
   always #5 ctrl_clk = ~ctrl_clk;

   task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [3:0] w0,
                                input logic [23:0] d0, input logic v1, input logic [15:0] a1,
                                input logic [3:0] w1, input logic [23:0] d1);
      req0_valid = v0; req0_addr = a0; req0_wr = w0; req0_wdat = d0;
      req1_valid = v1; req1_addr = a1; req1_wr = w1; req1_wdat = d1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Watchdog so a stuck design still terminates
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bad;
      ctrl_rst    = 1'b1;
      clear_start = 1'b0;
      clear_color = 24'h0;
      applyStimulus(0, 16'h0, 4'h0, 24'h0, 0, 16'h0, 4'h0, 24'h0);
      repeat (2) @(negedge ctrl_clk);

      checkOutput("rst_en",    32'(ctrl_en), 0);
      checkOutput("rst_wr",    32'(ctrl_wr), 0);
      checkOutput("rst_addr",  32'(ctrl_addr), 0);
      checkOutput("rst_wdat",  32'(ctrl_wdat), 0);
      checkOutput("rst_err",   32'(addr_err), 0);
      checkOutput("rst_busy",  32'(clear_busy), 0);
      checkOutput("rst_done",  32'(clear_done), 0);
      ctrl_rst = 1'b0;

      // Single requester write and one-cycle latency
      applyStimulus(1, 16'h0010, 4'b0111, 24'h3F2A15, 0, 16'h0, 4'h0, 24'h0);
      #1;
      checkOutput("t1_ready0", 32'(req0_ready), 1);
      checkOutput("t1_ready1", 32'(req1_ready), 0);
      @(negedge ctrl_clk);
      applyStimulus(0, 16'h0, 4'h0, 24'h0, 0, 16'h0, 4'h0, 24'h0);
      checkOutput("t1_en",   32'(ctrl_en), 1);
      checkOutput("t1_addr", 32'(ctrl_addr), 32'h0010);
      checkOutput("t1_wdat", 32'(ctrl_wdat), 32'h3F2A15);
      checkOutput("t1_wr",   32'(ctrl_wr), 32'h7);
      @(negedge ctrl_clk);
      checkOutput("idle_en",   32'(ctrl_en), 0);
      checkOutput("idle_wr",   32'(ctrl_wr), 0);
      checkOutput("idle_addr", 32'(ctrl_addr), 32'h0010);
      checkOutput("idle_wdat", 32'(ctrl_wdat), 32'h3F2A15);

      // Reset again so rr restarts favouring requester 0, then alternate under contention
      ctrl_rst = 1'b1;
      @(negedge ctrl_clk);
      ctrl_rst = 1'b0;
      checkOutput("rst2_addr", 32'(ctrl_addr), 0);
      applyStimulus(1, 16'h0100, 4'b1001, 24'h000001, 1, 16'h0200, 4'b0110, 24'h000002);
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("rr_ready0", 32'(req0_ready), (k % 2 == 0) ? 1 : 0);
         checkOutput("rr_ready1", 32'(req1_ready), (k % 2 == 1) ? 1 : 0);
         @(negedge ctrl_clk);
         checkOutput("rr_en",   32'(ctrl_en), 1);
         checkOutput("rr_addr", 32'(ctrl_addr), (k % 2 == 0) ? 32'h0100 : 32'h0200);
         checkOutput("rr_wr",   32'(ctrl_wr), (k % 2 == 0) ? 32'h1 : 32'h6);
         checkOutput("rr_wdat", 32'(ctrl_wdat), (k % 2 == 0) ? 32'h1 : 32'h2);
      end
      applyStimulus(0, 16'h0, 4'h0, 24'h0, 0, 16'h0, 4'h0, 24'h0);
      @(negedge ctrl_clk);
      checkOutput("rr_stop_en", 32'(ctrl_en), 0);

      // Lone req0 with wr=0 still writes and moves rr to requester 1
      applyStimulus(1, 16'h0ABC, 4'b0000, 24'hA5A5A5, 0, 16'h0, 4'h0, 24'h0);
      #1;
      checkOutput("wr0_ready0", 32'(req0_ready), 1);
      @(negedge ctrl_clk);
      checkOutput("wr0_en",   32'(ctrl_en), 1);
      checkOutput("wr0_wr",   32'(ctrl_wr), 0);
      checkOutput("wr0_addr", 32'(ctrl_addr), 32'h0ABC);
      applyStimulus(1, 16'h0001, 4'b0111, 24'h0, 1, 16'h0FFF, 4'b0100, 24'hFF0000);
      #1;
      checkOutput("pref_ready0", 32'(req0_ready), 0);
      checkOutput("pref_ready1", 32'(req1_ready), 1);
      @(negedge ctrl_clk);
      checkOutput("edge_en",   32'(ctrl_en), 1);
      checkOutput("edge_addr", 32'(ctrl_addr), 32'h0FFF);
      checkOutput("edge_err",  32'(addr_err), 0);

      // Out-of-range address: handshake happens but the write is dropped
      applyStimulus(1, 16'h1000, 4'b0111, 24'h123456, 0, 16'h0, 4'h0, 24'h0);
      #1;
      checkOutput("oor_ready0", 32'(req0_ready), 1);
      @(negedge ctrl_clk);
      applyStimulus(0, 16'h0, 4'h0, 24'h0, 1, 16'hFFFF, 4'b0111, 24'h654321);
      checkOutput("oor_en",   32'(ctrl_en), 0);
      checkOutput("oor_err",  32'(addr_err), 1);
      checkOutput("oor_addr", 32'(ctrl_addr), 32'h0FFF);
      #1;
      checkOutput("oor1_ready1", 32'(req1_ready), 1);
      @(negedge ctrl_clk);
      applyStimulus(0, 16'h0, 4'h0, 24'h0, 0, 16'h0, 4'h0, 24'h0);
      checkOutput("oor1_err", 32'(addr_err), 1);
      checkOutput("oor1_en",  32'(ctrl_en), 0);
      @(negedge ctrl_clk);
      checkOutput("err_pulse", 32'(addr_err), 0);

`ifdef LEDPANEL_ARB_CLEAR_EN
      // Full clear blocks req1 for DEPTH+1 cycles
      clear_start = 1'b1;
      clear_color = 24'h010203;
      applyStimulus(0, 16'h0, 4'h0, 24'h0, 1, 16'h0333, 4'b0111, 24'h111111);
      #1;
      checkOutput("clr_start_ready1", 32'(req1_ready), 0);
      @(negedge ctrl_clk);
      clear_start = 1'b0;
      bad = 0;
      for (int i = 0; i < 4096; i++) begin
         if (i == 100) begin
            clear_start = 1'b1;
            clear_color = 24'hFFFFFF;
         end else begin
            clear_start = 1'b0;
         end
         #1;
         if (ctrl_en !== 1'b1 || ctrl_addr !== 16'(i) || ctrl_wdat !== 24'h010203 ||
             ctrl_wr !== 4'b0111 || clear_busy !== 1'b1 || req1_ready !== 1'b0 ||
             clear_done !== (i == 4095)) bad++;
         @(negedge ctrl_clk);
      end
      clear_start = 1'b0;
      checkOutput("clr_bad_cycles", 32'(bad), 0);
      checkOutput("clr_busy_end", 32'(clear_busy), 0);
      checkOutput("clr_en_end",   32'(ctrl_en), 0);
      checkOutput("clr_done_end", 32'(clear_done), 0);
      #1;
      checkOutput("clr_ready1_after", 32'(req1_ready), 1);
      @(negedge ctrl_clk);
      applyStimulus(0, 16'h0, 4'h0, 24'h0, 0, 16'h0, 4'h0, 24'h0);
      checkOutput("clr_req1_addr", 32'(ctrl_addr), 32'h0333);

      // Reset in the middle of a clear aborts it
      clear_start = 1'b1;
      clear_color = 24'h0A0B0C;
      @(negedge ctrl_clk);
      clear_start = 1'b0;
      bad = 0;
      while (ctrl_addr !== 16'h0800 && bad < 5000) begin
         @(negedge ctrl_clk);
         bad++;
      end
      checkOutput("abort_reach_0800", 32'(ctrl_addr), 32'h0800);
      ctrl_rst = 1'b1;
      @(negedge ctrl_clk);
      ctrl_rst = 1'b0;
      checkOutput("abort_en",   32'(ctrl_en), 0);
      checkOutput("abort_addr", 32'(ctrl_addr), 0);
      checkOutput("abort_wdat", 32'(ctrl_wdat), 0);
      checkOutput("abort_busy", 32'(clear_busy), 0);
      clear_start = 1'b1;
      clear_color = 24'h0D0E0F;
      @(negedge ctrl_clk);
      clear_start = 1'b0;
      checkOutput("restart_en",   32'(ctrl_en), 1);
      checkOutput("restart_addr", 32'(ctrl_addr), 0);
      checkOutput("restart_wdat", 32'(ctrl_wdat), 32'h0D0E0F);
      ctrl_rst = 1'b1;
      @(negedge ctrl_clk);
      ctrl_rst = 1'b0;
`else
      // Without the clear engine clear_start is ignored and arbitration proceeds
      clear_start = 1'b1;
      clear_color = 24'h010203;
      applyStimulus(0, 16'h0, 4'h0, 24'h0, 1, 16'h0333, 4'b0111, 24'h111111);
      #1;
      checkOutput("noclr_ready1", 32'(req1_ready), 1);
      @(negedge ctrl_clk);
      clear_start = 1'b0;
      applyStimulus(0, 16'h0, 4'h0, 24'h0, 0, 16'h0, 4'h0, 24'h0);
      checkOutput("noclr_addr", 32'(ctrl_addr), 32'h0333);
      checkOutput("noclr_wdat", 32'(ctrl_wdat), 32'h111111);
      checkOutput("noclr_busy", 32'(clear_busy), 0);
      clear_start = 1'b1;
      @(negedge ctrl_clk);
      clear_start = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (ctrl_en !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) bad++;
         @(negedge ctrl_clk);
      end
      checkOutput("noclr_quiet", 32'(bad), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
